// File: rtl/ecc_pkg.sv
// Shared ECC arithmetic types: field width and the
// start/finish handshake state encoding used by point controllers.
package ecc_pkg;
  localparam int ECC_W = 256;
  typedef enum logic [1:0] {MM_IDLE, MM_RUN, MM_DONE} mm_state_t;
endpackage

// File: rtl/mod_add_cond.sv
// Modular add with a single conditional subtract.
// Requires x, y < n so that one subtract brings the sum below n.
module mod_add_cond
  import ecc_pkg::*;
#(
  parameter int W = ECC_W
) (
  input  logic [W+1:0] x,
  input  logic [W+1:0] y,
  input  logic [W+1:0] n,
  output logic [W+1:0] s
);
  logic [W+1:0] sum;

  assign sum = x + y;
  assign s   = (sum >= n) ? sum - n : sum;
endmodule

// File: rtl/mod_mul_serial.sv
// Bit-serial modular multiplier, LSB-first, one multiplier bit per clock.
// Result = (a * b) mod n after W+1 edges from an accepted start.
module mod_mul_serial
  import ecc_pkg::*;
#(
  parameter int W = ECC_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W:0]   i_n,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_result,
  output logic         o_finished,
  output logic         o_busy
);
  localparam int CW = $clog2(W) + 1;

  mm_state_t    state;
  mm_state_t    state_d;
  logic [CW-1:0] cnt;
  logic [W+1:0] n_reg;
  logic [W+1:0] acc;
  logic [W+1:0] a_sh;
  logic [W+1:0] acc_add;
  logic [W+1:0] a_dbl;
  logic [W-1:0] b_sh;
  logic         last;

  assign last = (cnt == CW'(W - 1));

  mod_add_cond #(.W(W)) u_acc (
    .x (acc),
    .y (a_sh),
    .n (n_reg),
    .s (acc_add)
  );

  mod_add_cond #(.W(W)) u_dbl (
    .x (a_sh),
    .y (a_sh),
    .n (n_reg),
    .s (a_dbl)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      MM_IDLE: if (i_start) state_d = MM_RUN;
      MM_RUN:  if (last) state_d = MM_DONE;
      MM_DONE: state_d = MM_IDLE;
      default: state_d = MM_IDLE;
    endcase
  end

  // b is consumed by shifting so bit cnt always sits at b_sh[0]
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= MM_IDLE;
      cnt        <= '0;
      n_reg      <= '0;
      acc        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      o_result   <= '0;
      o_finished <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_d;
      o_finished <= 1'b0;
      unique case (state)
        MM_IDLE: begin
          if (i_start) begin
            n_reg  <= {1'b0, i_n};
            a_sh   <= {2'b00, i_a};
            b_sh   <= i_b;
            acc    <= '0;
            cnt    <= '0;
            o_busy <= 1'b1;
          end
        end
        MM_RUN: begin
          if (b_sh[0]) acc <= acc_add;
          a_sh <= a_dbl;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CW'(1);
        end
        MM_DONE: begin
          o_result   <= acc[W-1:0];
          o_finished <= 1'b1;
          o_busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_mul_serial.sv
// Scoreboard bench for mod_mul_serial at W=8 and W=256.
// Expected products come from plain (a*b)%n arithmetic.
module tb_mod_mul_serial;
  typedef struct {
    logic [255:0] res;
    longint       due;
  } exp_t;

  localparam logic [256:0] P256 =
    257'h0ffffffff00000001000000000000000000000000ffffffffffffffffffffffff;

  logic clk = 0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // W=8 instance
  logic       rst8 = 1, st8 = 0;
  logic [8:0] n8 = 0;
  logic [7:0] a8 = 0, b8 = 0, res8;
  logic       fin8, busy8, rst8_q = 1;
  exp_t       q8[$];

  mod_mul_serial #(.W(8)) dut8 (
    .i_clk(clk), .i_rst(rst8), .i_start(st8),
    .i_n(n8), .i_a(a8), .i_b(b8),
    .o_result(res8), .o_finished(fin8), .o_busy(busy8)
  );

  // W=256 instance
  logic         rst256 = 1, st256 = 0;
  logic [256:0] n256 = 0;
  logic [255:0] a256 = 0, b256 = 0, res256;
  logic         fin256, busy256, rst256_q = 1;
  exp_t         q256[$];

  mod_mul_serial #(.W(256)) dut256 (
    .i_clk(clk), .i_rst(rst256), .i_start(st256),
    .i_n(n256), .i_a(a256), .i_b(b256),
    .o_result(res256), .o_finished(fin256), .o_busy(busy256)
  );

  always @(posedge clk) begin
    rst8_q   <= rst8;
    rst256_q <= rst256;
  end

  function automatic logic [255:0] ref_mod(input logic [256:0] n,
                                           input logic [255:0] a,
                                           input logic [255:0] b);
    logic [511:0] prod;
    prod = {256'b0, a} * {256'b0, b};
    return 256'(prod % {255'b0, n});
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitors: pop on every finished pulse, check value and latency
  logic       fin8_p = 0;
  logic [7:0] res8_p = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst8_q) begin
      chk("w8_pulse_width", 256'(fin8 & fin8_p), 256'd0);
      if (!fin8) chk("w8_result_hold", 256'(res8), 256'(res8_p));
    end
    if (fin8) begin
      if (q8.size() == 0) begin
        checks++; failures++;
        $display("FAIL w8_unexpected_finish actual=1 required=0");
      end else begin
        e = q8.pop_front();
        chk("w8_result", 256'(res8), e.res);
        chk("w8_latency", 256'(cyc), 256'(e.due));
      end
    end else if (q8.size() > 0 && cyc > q8[0].due) begin
      checks++; failures++;
      $display("FAIL w8_timeout actual=cycle%0d required=cycle%0d",
               cyc, q8[0].due);
      void'(q8.pop_front());
    end
    fin8_p = fin8;
    res8_p = res8;
  end

  logic         fin256_p = 0;
  logic [255:0] res256_p = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst256_q) begin
      chk("w256_pulse_width", 256'(fin256 & fin256_p), 256'd0);
      if (!fin256) chk("w256_result_hold", res256, res256_p);
    end
    if (fin256) begin
      if (q256.size() == 0) begin
        checks++; failures++;
        $display("FAIL w256_unexpected_finish actual=1 required=0");
      end else begin
        e = q256.pop_front();
        chk("w256_result", res256, e.res);
        chk("w256_latency", 256'(cyc), 256'(e.due));
      end
    end else if (q256.size() > 0 && cyc > q256[0].due) begin
      checks++; failures++;
      $display("FAIL w256_timeout actual=cycle%0d required=cycle%0d",
               cyc, q256[0].due);
      void'(q256.pop_front());
    end
    fin256_p = fin256;
    res256_p = res256;
  end

  task automatic go8(input logic [8:0] n, input logic [7:0] a,
                     input logic [7:0] b, input bit b2b);
    int t = 0;
    @(negedge clk);
    while (busy8 && t < 100) begin @(negedge clk); t++; end
    if (busy8) begin
      checks++; failures++;
      $display("FAIL w8_idle_wait actual=busy required=idle");
    end
    if (b2b) chk("w8_b2b_in_finish", 256'(fin8), 256'd1);
    n8 = n; a8 = a; b8 = b; st8 = 1;
    @(posedge clk); #1;
    st8 = 0;
    q8.push_back('{res: ref_mod({248'b0, n}, {248'b0, a}, {248'b0, b}),
                   due: cyc + 9});
  endtask

  task automatic go256(input logic [256:0] n, input logic [255:0] a,
                       input logic [255:0] b);
    int t = 0;
    @(negedge clk);
    while (busy256 && t < 1000) begin @(negedge clk); t++; end
    if (busy256) begin
      checks++; failures++;
      $display("FAIL w256_idle_wait actual=busy required=idle");
    end
    n256 = n; a256 = a; b256 = b; st256 = 1;
    @(posedge clk); #1;
    st256 = 0;
    q256.push_back('{res: ref_mod(n, a, b), due: cyc + 257});
  endtask

  initial begin
    logic [8:0]   rn8;
    logic [256:0] rn;
    repeat (3) @(posedge clk);
    #1;
    chk("w8_reset_result", 256'(res8), 256'd0);
    chk("w8_reset_finished", 256'(fin8), 256'd0);
    chk("w8_reset_busy", 256'(busy8), 256'd0);
    chk("w256_reset_result", res256, 256'd0);
    chk("w256_reset_busy", 256'(busy256), 256'd0);
    rst8 = 0; rst256 = 0;

    // W=8 directed
    go8(9'd251, 8'd17, 8'd23, 0);
    chk("w8_busy_after_accept", 256'(busy8), 256'd1);
    go8(9'd251, 8'd5, 8'd7, 1);
    go8(9'd251, 8'd250, 8'd250, 1);
    go8(9'd251, 8'd0, 8'd200, 1);
    go8(9'd251, 8'd1, 8'd137, 1);

    // start while busy: other operands presented, must be ignored
    go8(9'd251, 8'd17, 8'd23, 1);
    repeat (3) @(negedge clk);
    n8 = 9'd200; a8 = 8'd99; b8 = 8'd77; st8 = 1;
    @(posedge clk); #1;
    st8 = 0; a8 = 8'd3; b8 = 8'd4;
    go8(9'd256, 8'd255, 8'd255, 1);

    // reset during RUN: abort, no pulse
    go8(9'd251, 8'd100, 8'd100, 1);
    repeat (3) @(negedge clk);
    rst8 = 1;
    @(posedge clk); #1;
    rst8 = 0;
    q8.delete();
    chk("w8_abort_busy", 256'(busy8), 256'd0);
    chk("w8_abort_result", 256'(res8), 256'd0);
    chk("w8_abort_finished", 256'(fin8), 256'd0);
    go8(9'd251, 8'd17, 8'd23, 0);

    // reset and start at the same edge: reset wins
    repeat (12) @(negedge clk);
    rst8 = 1; st8 = 1;
    @(posedge clk); #1;
    rst8 = 0; st8 = 0;
    chk("w8_rst_over_start", 256'(busy8), 256'd0);

    // W=8 random, modulus up to 2^8
    for (int i = 0; i < 300; i++) begin
      rn8 = 9'($urandom_range(256, 1));
      go8(rn8, 8'($urandom % rn8), 8'($urandom % rn8), 0);
    end

    // W=256 directed
    go256(P256, 256'd2, 256'd3);
    go256(P256, 256'(P256 - 1), 256'd2);
    go256(257'd251, 256'd17, 256'd23);

    // W=256 random: P-256, 2^256 and arbitrary moduli
    for (int i = 0; i < 150; i++) begin
      case (i % 3)
        0: rn = P256;
        1: rn = {1'b0, rand256()};
        default: rn = (i % 2 == 0) ? {1'b1, 256'b0} : {1'b0, rand256()};
      endcase
      if (rn == 0) rn = 257'd1;
      go256(rn, 256'({1'b0, rand256()} % rn), 256'({1'b0, rand256()} % rn));
    end

    for (int t = 0; t < 600 && (q8.size() + q256.size()) > 0; t++)
      @(posedge clk);
    @(negedge clk);
    if (q8.size() + q256.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain actual=%0d required=0", q8.size() + q256.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
